// File: rtl/float_sub_seq.sv
// float_sub_seq: multi-cycle IEEE-754 single-precision subtractor, result = a - b (optional special operands: FLOAT_SUB_SPECIAL_EN)
module float_sub_seq #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [EXP_W+MANT_W:0]     a,
    input  logic [EXP_W+MANT_W:0]     b,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      ovf
);
    localparam int W    = 1 + EXP_W + MANT_W;
    localparam int M    = MANT_W + 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;

    state_t             state, nxt;
    logic [W-1:0]       ra, rb, res_n, spec_val;
    logic               ovf_n, s_q, sub_q, accept, spec, a_ge, norm_fin;
    logic [EXP_W-1:0]   ea, eb, xe, d;
    logic [M-1:0]       ma, mb, xm, ym, xm_q, ym_q;
    logic [M:0]         m_q;
    logic [EXP_W:0]     e_q, e_inc, e_dec;

`ifdef FLOAT_SUB_SPECIAL_EN
    logic ia, ib, nan;
    // decode NaN/infinity directly on the live inputs so the accept cycle can bypass the datapath
    always_comb begin
        ia       = a[W-2:MANT_W] == '1;
        ib       = b[W-2:MANT_W] == '1;
        nan      = (ia && a[MANT_W-1:0] != '0) || (ib && b[MANT_W-1:0] != '0);
        spec     = ia || ib;
        spec_val = (nan || (ia && ib && a[W-1] == b[W-1])) ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}}
                 : ia ? a : {~b[W-1], b[W-2:0]};
    end
`else
    assign spec     = 1'b0;
    assign spec_val = '0;
`endif

    // operand alignment: flush denormals, pick larger magnitude, right-shift the smaller one
    always_comb begin
        ea   = ra[W-2:MANT_W];
        eb   = rb[W-2:MANT_W];
        ma   = (ea == '0) ? '0 : {1'b1, ra[MANT_W-1:0]};
        mb   = (eb == '0) ? '0 : {1'b1, rb[MANT_W-1:0]};
        a_ge = {ea, ma} >= {eb, mb};
        xe   = a_ge ? ea : eb;
        d    = a_ge ? ea - eb : eb - ea;
        xm   = a_ge ? ma : mb;
        ym   = (d >= EXP_W'(M + 1)) ? '0 : (a_ge ? mb : ma) >> d;
    end

    // normalisation step helpers and completion test
    always_comb begin
        e_inc    = e_q + 1'b1;
        e_dec    = e_q - 1'b1;
        norm_fin = m_q[M] || m_q == '0 || m_q[M-1] || e_dec == '0;
    end

    // next-state logic; start coinciding with done is ignored
    always_comb begin
        nxt    = state;
        accept = state == IDLE && start && !done;
        case (state)
            IDLE:    nxt = accept ? (spec ? DONE : ALIGN) : IDLE;
            ALIGN:   nxt = SUB;
            SUB:     nxt = NORM;
            NORM:    nxt = norm_fin ? DONE : NORM;
            default: nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    ra    <= a;
                    rb    <= b;
                    busy  <= 1'b1;
                    res_n <= spec_val;
                    ovf_n <= 1'b0;
                end
                ALIGN: begin
                    e_q   <= {1'b0, xe};
                    xm_q  <= xm;
                    ym_q  <= ym;
                    s_q   <= a_ge ? ra[W-1] : ~rb[W-1];
                    sub_q <= ra[W-1] == rb[W-1];
                end
                SUB: m_q <= sub_q ? {1'b0, xm_q} - {1'b0, ym_q} : {1'b0, xm_q} + {1'b0, ym_q};
                NORM: begin
                    if (m_q[M]) begin
                        ovf_n <= e_inc >= (EXP_W+1)'(EMAX);
                        res_n <= (e_inc >= (EXP_W+1)'(EMAX)) ? {s_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                               : {s_q, e_inc[EXP_W-1:0], m_q[MANT_W:1]};
                    end else if (m_q == '0) begin
                        res_n <= '0;
                    end else if (m_q[M-1]) begin
                        res_n <= {s_q, e_q[EXP_W-1:0], m_q[MANT_W-1:0]};
                    end else begin
                        m_q <= m_q << 1;
                        e_q <= e_dec;
                        if (e_dec == '0) res_n <= {s_q, {(W-1){1'b0}}};
                    end
                end
                DONE: begin
                    result <= res_n;
                    ovf    <= ovf_n;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
